vote_logger: RTL
================

Name: vote_logger

Overview:
- Front end of the voting machine. Conditions the four raw candidate push-buttons and validates each press as a vote.
- Keeps per-candidate 8-bit tallies.
- Drives the mode/LED controller through valid_vote_casted, candidateN_vote and candidateN_button_press.
- Sits between the board buttons and the mode/LED controller, on the same clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronized samples required before a debounced level changes (>=2).
- CNT_W, 8, tally width; fixed at 8 to match the LED controller.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = voting mode, 1 = result mode.
- candidate1_button  input  1  raw button, asynchronous to clock.
- candidate2_button  input  1  raw button.
- candidate3_button  input  1  raw button.
- candidate4_button  input  1  raw button.
- candidate1_button_press  output  1  debounced level of button 1.
- candidate2_button_press  output  1  debounced level of button 2.
- candidate3_button_press  output  1  debounced level of button 3.
- candidate4_button_press  output  1  debounced level of button 4.
- valid_vote_casted  output  1  one-cycle pulse per accepted vote.
- candidate1_vote  output  8  tally for candidate 1.
- candidate2_vote  output  8  tally for candidate 2.
- candidate3_vote  output  8  tally for candidate 3.
- candidate4_vote  output  8  tally for candidate 4.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all tallies 0, synchronizers and debounce counters cleared, FSM in IDLE. Release is sampled on the clock.
- Synchronizer: two flops per raw button.
- Debounce, per button:
  - When the synchronized value differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - candidateN_button_press is the registered debounced level.
- Latency: raw edge held stable to debounced edge = DEBOUNCE_CYCLES+2 clocks. Debounced rise to valid_vote_casted high = 1 clock.
- FSM states:
  - IDLE:
    - mode=0 and exactly one debounced level high -> CAST.
    - mode=0 and two or more high -> REJECT.
    - mode=1 -> stay; no votes are counted in result mode.
  - CAST, one cycle:
    - valid_vote_casted=1.
    - Matching tally increments on the same edge that enters CAST, so the new value is visible while the pulse is high.
    - Always -> WAIT_RELEASE.
  - REJECT: no pulse, no tally change -> WAIT_RELEASE.
  - WAIT_RELEASE: stay until all four debounced levels are 0, then -> IDLE. Holding a button therefore casts exactly one vote.
- Boundary conditions:
  - Simultaneous debounced rises on two or more buttons in the same cycle go to REJECT.
  - A second button pressed while the first is held in WAIT_RELEASE casts nothing.
  - A tally saturates at 255. A vote for a saturated candidate still pulses valid_vote_casted and the tally stays 255.
  - mode changing 0->1 while in CAST: the vote completes. mode is sampled only in IDLE.
  - Reset mid-operation, including mid-CAST, clears tallies and the pulse immediately.
- valid_vote_casted is never high for two consecutive cycles.

Optional Feature:
- Macro: VOTE_LOGGER_TOTAL_EN.
- Defined:
  - Adds output total_votes [9:0], reset 0.
  - Increments on every CAST and saturates at 1023.
  - Counts votes for a saturated candidate too.
  - Adds output reject_seen [0:0]: set on entry to REJECT, cleared by reset only.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, mode=0, candidate2_button held high for 20 clocks -> candidate2_button_press rises 6 clocks after the raw edge. One valid_vote_casted pulse follows 1 clock later with candidate2_vote=1, and no further pulse while held.
- Raw candidate1_button toggles every 2 clocks for 30 clocks, then settles low -> candidate1_button_press stays 0, no pulse, tallies 0.
- candidate3_button and candidate4_button raised in the same cycle, held 10 clocks, released -> no pulse, tallies unchanged. A following clean candidate3 press yields candidate3_vote=1.
- 260 clean presses of candidate4 (debounced low between presses) -> 260 pulses and candidate4_vote=255. With VOTE_LOGGER_TOTAL_EN defined, total_votes=260.
- mode=1, candidate1 pressed -> candidate1_button_press=1, no pulse, candidate1_vote unchanged.
- reset asserted low during the CAST cycle after votes of 5/3/0/1 -> all tallies and valid_vote_casted read 0 immediately. FSM restarts in IDLE.

Source files
------------

// File: rtl/vote_logger.sv
// Voting front end: synchronizes and debounces four candidate buttons, validates presses as votes
// and keeps saturating per-candidate tallies. Define VOTE_LOGGER_TOTAL_EN for total/reject outputs.
module vote_logger #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic             candidate1_button,
    input  logic             candidate2_button,
    input  logic             candidate3_button,
    input  logic             candidate4_button,
    output logic             candidate1_button_press,
    output logic             candidate2_button_press,
    output logic             candidate3_button_press,
    output logic             candidate4_button_press,
    output logic             valid_vote_casted,
    output logic [CNT_W-1:0] candidate1_vote,
    output logic [CNT_W-1:0] candidate2_vote,
    output logic [CNT_W-1:0] candidate3_vote,
    output logic [CNT_W-1:0] candidate4_vote
`ifdef VOTE_LOGGER_TOTAL_EN
    ,
    output logic [9:0]       total_votes,
    output logic [0:0]       reject_seen
`endif
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TallyMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StCast,
        StReject,
        StWaitRelease
    } state_e;

    logic [3:0]                 btn_raw;
    logic [3:0]                 sync1_q, sync2_q;
    logic [3:0]                 level_q, level_d;
    logic [3:0][DbW-1:0]        db_cnt_q, db_cnt_d;
    logic [3:0][CNT_W-1:0]      tally_q, tally_d;
    logic [2:0]                 n_high;
    state_e                     state_q, state_d;

    assign btn_raw = {candidate4_button, candidate3_button, candidate2_button, candidate1_button};

    // Two-flop synchronizer per raw button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        n_high = '0;
        for (int i = 0; i < 4; i++) begin
            n_high = n_high + 3'(level_q[i]);
        end
    end

    // Tally bumps on the edge entering StCast so it is visible alongside the pulse.
    always_comb begin
        state_d = state_q;
        tally_d = tally_q;
        case (state_q)
            StIdle: begin
                if (!mode) begin
                    if (n_high == 3'd1) begin
                        state_d = StCast;
                        for (int i = 0; i < 4; i++) begin
                            if (level_q[i] && (tally_q[i] != TallyMax)) begin
                                tally_d[i] = tally_q[i] + CNT_W'(1);
                            end
                        end
                    end else if (n_high >= 3'd2) begin
                        state_d = StReject;
                    end
                end
            end
            StCast:        state_d = StWaitRelease;
            StReject:      state_d = StWaitRelease;
            StWaitRelease: begin
                if (level_q == 4'b0000) begin
                    state_d = StIdle;
                end
            end
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            tally_q <= tally_d;
        end
    end

    assign valid_vote_casted       = (state_q == StCast);
    assign candidate1_button_press = level_q[0];
    assign candidate2_button_press = level_q[1];
    assign candidate3_button_press = level_q[2];
    assign candidate4_button_press = level_q[3];
    assign candidate1_vote         = tally_q[0];
    assign candidate2_vote         = tally_q[1];
    assign candidate3_vote         = tally_q[2];
    assign candidate4_vote         = tally_q[3];

`ifdef VOTE_LOGGER_TOTAL_EN
    logic [9:0] total_q, total_d;
    logic       reject_q, reject_d;

    // StCast and StReject are only ever entered from StIdle.
    always_comb begin
        total_d  = total_q;
        reject_d = reject_q;
        if ((state_d == StCast) && (state_q != StCast) && (total_q != 10'h3FF)) begin
            total_d = total_q + 10'd1;
        end
        if ((state_d == StReject) && (state_q != StReject)) begin
            reject_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            total_q  <= total_d;
            reject_q <= reject_d;
        end
    end

    assign total_votes = total_q;
    assign reject_seen = reject_q;
`endif

endmodule
